// File: rtl/mem_reader.sv
// Button- or run-triggered single-word memory reader: a debounced press (or run)
// wins the bus, reads one word at the pointer, presents it with a valid pulse.
module mem_reader #(
    parameter int ADDR_WIDTH      = 6,
    parameter int DATA_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_n,
    input  logic                  run,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    output logic                  bus_req,
    input  logic                  bus_gnt,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic [2:0]            dbg_state,
    output logic [ADDR_WIDTH-1:0] dbg_ptr
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        ADDR    = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t                r_state;
    state_t                w_next;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_btn_lvl;
    logic [CNT_W-1:0]      r_db_cnt;
    logic                  r_press;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_addr_out;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid;
    logic                  w_db_flip;

    // The debounced level only flips after DEBOUNCE_CYCLES consecutive samples
    // disagreeing with it, so one press event fires per press and a new one
    // needs a fully debounced release first.
    assign w_db_flip = (r_sync2 != r_btn_lvl) && (r_db_cnt == DB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_btn_lvl <= 1'b1;
            r_db_cnt  <= '0;
            r_press   <= 1'b0;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
            r_press <= w_db_flip && !r_sync2;
            if (r_sync2 == r_btn_lvl) begin
                r_db_cnt <= '0;
            end else if (w_db_flip) begin
                r_db_cnt  <= '0;
                r_btn_lvl <= r_sync2;
            end else begin
                r_db_cnt <= r_db_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // bus_req/bus_gnt: bus_req is held while a read is in flight (REQ, ADDR,
    // WAIT); the bus is ours only in cycles where bus_gnt is sampled high, and
    // losing it in ADDR/WAIT abandons the access and re-requests.
    always_comb begin
        w_next   = r_state;
        bus_req  = 1'b0;
        mem_addr = '0;
        case (r_state)
            IDLE: begin
                if (!load && (r_press || run)) w_next = REQ;
            end
            REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) w_next = ADDR;
            end
            ADDR: begin
                bus_req  = 1'b1;
                mem_addr = r_ptr;
                w_next   = bus_gnt ? WAIT : REQ;
            end
            WAIT: begin
                bus_req  = 1'b1;
                mem_addr = r_ptr;
                w_next   = bus_gnt ? CAPTURE : REQ;
            end
            CAPTURE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_addr_out <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= (r_state == CAPTURE);
            if (r_state == IDLE && load) begin
                r_ptr <= start_addr;
            end else if (r_state == CAPTURE) begin
                r_data_out <= mem_in;
                r_addr_out <= r_ptr;
                r_ptr      <= r_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    assign mem_we    = 1'b0;
    assign addr_out  = r_addr_out;
    assign data_out  = r_data_out;
    assign valid     = r_valid;
    assign dbg_state = r_state;
    assign dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_mem_reader.sv
// Directed bench for mem_reader: vector table of run-triggered reads plus
// hand-written press, glitch, run-stream, grant-drop and reset sequences.
module tb_mem_reader;

    localparam int AW = 6;
    localparam int DW = 16;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;

    typedef struct {
        bit            do_load;
        logic [AW-1:0] start;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic [AW-1:0] exp_ptr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_n = 1'b1;
    logic          run = 1'b0;
    logic          load = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          bus_req;
    logic          bus_gnt = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_q = '0;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] data_out;
    logic          valid;
    logic [2:0]    dbg_state;
    logic [AW-1:0] dbg_ptr;

    logic [DW-1:0] mem [64];
    logic [AW-1:0] exp_q [$];
    vec_t          vecs [5];
    int            checks = 0;
    int            failures = 0;

    mem_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .run(run), .load(load),
        .start_addr(start_addr), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_in(mem_q),
        .addr_out(addr_out), .data_out(data_out), .valid(valid),
        .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_q <= mem[mem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        btn_n = 1'b0;
        repeat (8) tick();
        btn_n = 1'b1;
    endtask

    task automatic load_ptr(input logic [AW-1:0] a);
        load = 1'b1;
        start_addr = a;
        tick();
        load = 1'b0;
    endtask

    task automatic run_pulse();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic observe(input int n, output int cnt, output logic [AW-1:0] a,
                           output logic [DW-1:0] d);
        cnt = 0;
        a = '0;
        d = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (valid) begin
                cnt++;
                a = addr_out;
                d = data_out;
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (dbg_state == s) ok = 1'b1;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_valid(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (valid) ok = 1'b1;
        end
        chk(name, 32'(ok), 32'd1);
        if (ok) begin
            tick();
            chk({name, "_width"}, 32'(valid), 32'd0);
        end
    endtask

    initial begin
        int            cnt;
        int            breq;
        int            busy;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        for (int i = 0; i < 64; i++) mem[i] = (i == 0) ? 16'h1234 : (16'hA000 | 16'(i));
        vecs[0] = '{1'b1, 6'd10, 6'd10, 16'hA00A, 6'd11};
        vecs[1] = '{1'b0, 6'd0,  6'd11, 16'hA00B, 6'd12};
        vecs[2] = '{1'b1, 6'd62, 6'd62, 16'hA03E, 6'd63};
        vecs[3] = '{1'b0, 6'd0,  6'd63, 16'hA03F, 6'd0};
        vecs[4] = '{1'b0, 6'd0,  6'd0,  16'h1234, 6'd1};

        // Reset values
        #2;
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_addr_out", 32'(addr_out), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
        chk("rst_ptr", 32'(dbg_ptr), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single press read of word 0
        bus_gnt = 1'b1;
        press();
        observe(25, cnt, a, d);
        chk("press_count", 32'(cnt), 1);
        chk("press_addr", 32'(a), 0);
        chk("press_data", 32'(d), 32'h1234);
        chk("press_ptr", 32'(dbg_ptr), 1);
        chk("press_hold_data", 32'(data_out), 32'h1234);

        // Load 63, two presses wrap to 0
        load_ptr(6'd63);
        chk("load_ptr", 32'(dbg_ptr), 63);
        press();
        observe(25, cnt, a, d);
        chk("wrap1_count", 32'(cnt), 1);
        chk("wrap1_addr", 32'(a), 63);
        chk("wrap1_data", 32'(d), 32'hA03F);
        press();
        observe(25, cnt, a, d);
        chk("wrap2_count", 32'(cnt), 1);
        chk("wrap2_addr", 32'(a), 0);
        chk("wrap2_data", 32'(d), 32'h1234);
        chk("wrap2_ptr", 32'(dbg_ptr), 1);

        // Short glitch must be ignored
        btn_n = 1'b0;
        repeat (3) tick();
        btn_n = 1'b1;
        breq = 0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_req) breq++;
            if (valid) cnt++;
        end
        chk("glitch_bus_req", 32'(breq), 0);
        chk("glitch_valid", 32'(cnt), 0);
        chk("glitch_state", 32'(dbg_state), 32'(S_IDLE));

        // Continuous run for 20 cycles: words 0..3, 5 cycles apart
        load_ptr(6'd0);
        for (int k = 0; k < 4; k++) exp_q.push_back(AW'(k));
        cnt = 0;
        run = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (valid) begin
                cnt++;
                chk("run_cycle", 32'(i), 32'(5 * cnt));
                if (exp_q.size() > 0) chk("run_addr", 32'(addr_out), 32'(exp_q.pop_front()));
                else chk("run_extra", 32'(addr_out), 32'hFFFF);
            end
        end
        run = 1'b0;
        chk("run_count", 32'(cnt), 4);
        chk("run_queue_empty", 32'(exp_q.size()), 0);
        chk("run_ptr", 32'(dbg_ptr), 4);

        // Grant dropped in WAIT, press during stall is dropped
        run_pulse();
        wait_state(S_WAIT, 10, "drop_reach_wait");
        bus_gnt = 1'b0;
        tick();
        chk("drop_state", 32'(dbg_state), 32'(S_REQ));
        chk("drop_bus_req", 32'(bus_req), 1);
        chk("drop_ptr", 32'(dbg_ptr), 4);
        cnt = 0;
        press();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid) cnt++;
        end
        chk("drop_no_valid", 32'(cnt), 0);
        chk("drop_still_req", 32'(dbg_state), 32'(S_REQ));
        bus_gnt = 1'b1;
        wait_valid(10, "regrant_valid");
        chk("regrant_addr", 32'(addr_out), 4);
        chk("regrant_data", 32'(data_out), 32'hA004);
        busy = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dbg_state != S_IDLE) busy++;
        end
        chk("press_dropped", 32'(busy), 0);

        // Table of run-triggered single reads
        for (int k = 0; k < 5; k++) begin
            if (vecs[k].do_load) load_ptr(vecs[k].start);
            run_pulse();
            wait_valid(10, "tbl_valid");
            chk("tbl_addr", 32'(addr_out), 32'(vecs[k].exp_addr));
            chk("tbl_data", 32'(data_out), 32'(vecs[k].exp_data));
            chk("tbl_ptr", 32'(dbg_ptr), 32'(vecs[k].exp_ptr));
        end

        // Reset during ADDR aborts the read
        run_pulse();
        wait_state(S_ADDR, 10, "rst_reach_addr");
        rst_n = 1'b0;
        #1;
        chk("abort_bus_req", 32'(bus_req), 0);
        chk("abort_mem_addr", 32'(mem_addr), 0);
        chk("abort_valid", 32'(valid), 0);
        chk("abort_addr_out", 32'(addr_out), 0);
        chk("abort_data_out", 32'(data_out), 0);
        chk("abort_state", 32'(dbg_state), 32'(S_IDLE));
        chk("abort_ptr", 32'(dbg_ptr), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (valid) cnt++;
        end
        chk("abort_no_valid", 32'(cnt), 0);
        chk("abort_idle", 32'(dbg_state), 32'(S_IDLE));
        press();
        observe(25, cnt, a, d);
        chk("after_rst_count", 32'(cnt), 1);
        chk("after_rst_addr", 32'(a), 0);
        chk("after_rst_data", 32'(d), 32'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
